// File: rtl/agu_read_engine_if.sv
// Signal bundle between the AGU-facing read engine and its surroundings: control,
// address stream, memory read port and the buffered read-data output.
interface agu_read_engine_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic              start;
    logic [63:0]       transfer_size;
    logic [ADDR_W-1:0] addr_in;
    logic              addr_valid;
    logic              addr_ready;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              busy;
    logic              done;

    // Engine side.
    modport slave (
        input  start, transfer_size, addr_in, addr_valid, mem_rdata, data_ready,
        output addr_ready, mem_req, mem_addr, data_out, data_valid, busy, done
    );

    // Environment side: AGU, memory and downstream consumer.
    modport master (
        output start, transfer_size, addr_in, addr_valid, mem_rdata, data_ready,
        input  addr_ready, mem_req, mem_addr, data_out, data_valid, busy, done
    );
endinterface

// File: rtl/agu_read_engine.sv
// Read engine: issues one 1-cycle-latency memory read per accepted AGU address and
// returns the words in order through a small credit-protected FIFO.
module agu_read_engine #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    agu_read_engine_if.slave bus_io
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned OccW = CntW + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [63:0]       size_q, size_d;
    logic [63:0]       issued_q, issued_d;
    logic [63:0]       delivered_q, delivered_d;
    logic              inflight_q;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    logic            addr_ready;
    logic            accept;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            credit_ok;
    logic [OccW-1:0] occupancy;

    // Words already buffered plus the read still in flight must fit in the FIFO,
    // so a capture can never find it full.
    assign occupancy  = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
    assign credit_ok  = occupancy < OccW'(FIFO_DEPTH);
    assign addr_ready = (state_q == StRun) && (issued_q < size_q) && credit_ok;
    assign accept     = bus_io.addr_valid && addr_ready;
    assign push       = inflight_q;
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && bus_io.data_ready;
    assign count_d    = count_q + CntW'(push) - CntW'(pop);

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        if (accept) begin
            issued_d = issued_q + 64'd1;
        end
        if (pop) begin
            delivered_d = delivered_q + 64'd1;
        end
        case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    size_d      = bus_io.transfer_size;
                    issued_d    = '0;
                    delivered_d = '0;
                    state_d     = (bus_io.transfer_size == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (issued_q == size_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Look at the post-pop count so done follows the last pop by one cycle.
                if (delivered_d == size_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            size_q      <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            inflight_q  <= accept;
            count_q     <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // Storage needs no reset: the cleared count hides whatever it holds.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus_io.mem_rdata;
        end
    end

    assign bus_io.addr_ready = addr_ready;
    assign bus_io.mem_req    = accept;
    assign bus_io.mem_addr   = bus_io.addr_in[ADDR_W-1:0];
    assign bus_io.data_valid = !fifo_empty;
    assign bus_io.data_out   = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
    assign bus_io.busy       = (state_q != StIdle);
    assign bus_io.done       = (state_q == StDone);
endmodule
